fpu_ss_mem_tracker: RTL and testbench
=====================================

Name: fpu_ss_mem_tracker

Overview:
- Tracks outstanding load/store requests that the FPU subsystem controller has offloaded to the core over the X-interface memory channel.
- The controller pushes one metadata entry per accepted memory request (x_mem_valid & x_mem_ready) and pops the oldest entry when x_mem_result_valid returns.
- The head entry (rd, we, id) steers FP register-file writeback and load forwarding.
- Sits directly downstream of the controller's mem_push/mem_pop handshake.

Parameters:
- DEPTH, 4, number of outstanding memory requests; any integer >= 1, not required to be a power of two.
- CNT_W, $clog2(DEPTH+1), width of usage_o (derived; do not override).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- push_valid_i  in  1  new request accepted by the core (the controller's mem_push_valid_o).
- push_ready_o  out  1  space available (to the controller's mem_push_ready_i).
- push_data_i  in  mem_metadata_t  {rd[4:0], we, id[3:0]} of the request.
- pop_valid_o  out  1  head entry valid (the controller's mem_pop_valid_i).
- pop_ready_i  in  1  consume head (the controller's mem_pop_ready_o, i.e. x_mem_result_valid).
- pop_data_o  out  mem_metadata_t  head entry (the controller's mem_pop_i).
- flush_i  in  1  discard all entries (kill or recovery).
- usage_o  out  CNT_W  number of valid entries.
- full_o  out  1  usage_o == DEPTH.
- empty_o  out  1  usage_o == 0.
- overflow_o  out  1  sticky: push attempted while full.
- underflow_o  out  1  sticky: pop attempted while empty.

Behaviour:
- Clock and reset: one clock (clk_i). Reset is synchronous and active-high (rst_i).
- Reset values:
  - rptr, wptr and count are 0.
  - pop_valid_o=0, empty_o=1, full_o=0, usage_o=0, overflow_o=0, underflow_o=0, push_ready_o=1.
  - pop_data_o='0.
- Storage: DEPTH-entry register array, not reset. Only pointers and count are reset.
- Pointers: rptr and wptr range 0..DEPTH-1 and wrap explicitly from DEPTH-1 to 0. Do not rely on power-of-two overflow. count is 0..DEPTH.
- push_ready_o = ~full_o. Combinational from state only; no dependence on pop_ready_i, so no fall-through and no bypass.
- Push: when push_valid_i & push_ready_o, write mem[wptr] <= push_data_i and advance wptr.
  - The entry is visible on pop_data_o from the next cycle.
  - Minimum push-to-pop_valid latency is 1 cycle.
- Pop: pop_valid_o = ~empty_o. When pop_valid_o & pop_ready_i, advance rptr.
- pop_data_o = mem[rptr] when non-empty, else '0. It is combinational from registered state.
- Simultaneous push and pop (non-empty, not full): both pointers advance and count is unchanged.
- Simultaneous push and pop when full: push is refused (push_ready_o=0) and the pop proceeds.
- Push while full (push_valid_i & full_o): data dropped, state unchanged, overflow_o set. overflow_o stays set until rst_i.
- Pop while empty (pop_ready_i & empty_o): ignored, underflow_o set. underflow_o stays set until rst_i.
- flush_i: next cycle rptr=wptr=0 and count=0.
  - flush_i has priority over a same-cycle push or pop; that push is discarded.
  - flush_i does not clear overflow_o or underflow_o.
- rst_i has priority over flush_i and all traffic. Reset mid-operation discards all entries; the next push after reset lands at index 0.
- usage_o, full_o and empty_o are decoded from the registered count; no glitch paths from inputs.

Decomposition:
- fpu_ss_pkg holds mem_metadata_t (rd logic[4:0], we logic, id logic[3:0]) together with the existing op_select_e and x_commit_t.
- No sub-module. A local pointer-increment function implements the wrap at DEPTH-1.

Test Plan:
- Reset, then push {rd=5,we=1,id=3} -> next cycle pop_valid_o=1, pop_data_o.rd=5, usage_o=1. Pop -> empty_o=1, pop_data_o='0.
- DEPTH=4: push ids 0,1,2,3 on consecutive cycles -> full_o=1, push_ready_o=0. A fifth push -> overflow_o=1 and the head still has id=0. Pop four times -> ids 0,1,2,3 in order.
- DEPTH=3 (non power of two): sustained 1-push/1-pop per cycle for 10 cycles after one pre-push -> usage_o stays 1, ids return in order across the pointer wrap.
- Full FIFO with push and pop in the same cycle -> pop accepted, push refused, usage_o goes 4 -> 3, overflow_o set.
- Two entries plus flush_i together with a push of id=7 -> next cycle empty_o=1, usage_o=0. The next push of id=9 pops back id=9.
- pop_ready_i with FIFO empty -> underflow_o=1 and pointers unchanged. Assert rst_i mid-traffic (2 entries) -> all outputs return to reset values in the following cycle.

Source files
------------

// File: rtl/fpu_ss_pkg.sv
// Shared types for the FPU subsystem.
//   op_select_e    : execution-unit selector for an offloaded instruction
//   x_commit_t     : X-interface commit transaction
//   mem_metadata_t : per-request bookkeeping kept while a load/store is
//                    outstanding on the X-interface memory channel
package fpu_ss_pkg;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_FPU  = 2'd1,
    OP_MEM  = 2'd2,
    OP_CSR  = 2'd3
  } op_select_e;

  typedef struct packed {
    logic [3:0] id;
    logic       commit_kill;
  } x_commit_t;

  typedef struct packed {
    logic [4:0] rd;
    logic       we;
    logic [3:0] id;
  } mem_metadata_t;

endpackage

// File: rtl/fpu_ss_mem_tracker.sv
// In-order tracker for load/store requests offloaded to the core.
// One metadata entry is pushed per accepted memory request and the oldest
// is popped when its result returns; the head steers FP writeback.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   push_valid_i/ready_o/data_i  new request metadata
//   pop_valid_o/ready_i/data_o   head entry, consumed on result return
//   flush_i                      drop every entry
//   usage_o, full_o, empty_o     occupancy, decoded from the registered count
//   overflow_o, underflow_o      sticky error flags, cleared only by rst_i
module fpu_ss_mem_tracker
  import fpu_ss_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH+1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_valid_i,
  output logic             push_ready_o,
  input  mem_metadata_t    push_data_i,
  output logic             pop_valid_o,
  input  logic             pop_ready_i,
  output mem_metadata_t    pop_data_o,
  input  logic             flush_i,
  output logic [CNT_W-1:0] usage_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Explicit wrap so any DEPTH works, not only powers of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  mem_metadata_t    r_mem [DEPTH];
  logic [PTR_W-1:0] r_rptr, r_wptr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf, r_udf;

  logic w_push, w_pop;

  assign full_o       = (r_cnt == CNT_W'(DEPTH));
  assign empty_o      = (r_cnt == '0);
  assign usage_o      = r_cnt;
  assign push_ready_o = ~full_o;
  assign pop_valid_o  = ~empty_o;
  assign pop_data_o   = empty_o ? '0 : r_mem[r_rptr];
  assign overflow_o   = r_ovf;
  assign underflow_o  = r_udf;

  // A flush discards same-cycle traffic, so neither side is accepted.
  assign w_push = push_valid_i & push_ready_o & ~flush_i;
  assign w_pop  = pop_valid_o  & pop_ready_i  & ~flush_i;

  // Payload storage carries no reset; validity lives in the pointers/count.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= push_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rptr <= '0;
      r_wptr <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
      r_udf  <= 1'b0;
    end else begin
      // Error flags are sticky and survive a flush.
      if (push_valid_i & full_o) r_ovf <= 1'b1;
      if (pop_ready_i & empty_o) r_udf <= 1'b1;
      if (flush_i) begin
        r_rptr <= '0;
        r_wptr <= '0;
        r_cnt  <= '0;
      end else begin
        if (w_push) r_wptr <= ptr_inc(r_wptr);
        if (w_pop)  r_rptr <= ptr_inc(r_rptr);
        case ({w_push, w_pop})
          2'b10:   r_cnt <= r_cnt + 1'b1;
          2'b01:   r_cnt <= r_cnt - 1'b1;
          default: r_cnt <= r_cnt;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fpu_ss_mem_tracker.sv
module tb_fpu_ss_mem_tracker;
  import fpu_ss_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DEPTH=4 instance
  logic          a_push_valid, a_push_ready, a_pop_valid, a_pop_ready, a_flush;
  mem_metadata_t a_push_data, a_pop_data;
  logic [2:0]    a_usage;
  logic          a_full, a_empty, a_ovf, a_udf;

  // DEPTH=3 instance
  logic          b_push_valid, b_push_ready, b_pop_valid, b_pop_ready, b_flush;
  mem_metadata_t b_push_data, b_pop_data;
  logic [1:0]    b_usage;
  logic          b_full, b_empty, b_ovf, b_udf;

  fpu_ss_mem_tracker #(.DEPTH(4)) u_a (
    .clk_i(clk), .rst_i(rst),
    .push_valid_i(a_push_valid), .push_ready_o(a_push_ready), .push_data_i(a_push_data),
    .pop_valid_o(a_pop_valid), .pop_ready_i(a_pop_ready), .pop_data_o(a_pop_data),
    .flush_i(a_flush), .usage_o(a_usage), .full_o(a_full), .empty_o(a_empty),
    .overflow_o(a_ovf), .underflow_o(a_udf)
  );

  fpu_ss_mem_tracker #(.DEPTH(3)) u_b (
    .clk_i(clk), .rst_i(rst),
    .push_valid_i(b_push_valid), .push_ready_o(b_push_ready), .push_data_i(b_push_data),
    .pop_valid_o(b_pop_valid), .pop_ready_i(b_pop_ready), .pop_data_o(b_pop_data),
    .flush_i(b_flush), .usage_o(b_usage), .full_o(b_full), .empty_o(b_empty),
    .overflow_o(b_ovf), .underflow_o(b_udf)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic mem_metadata_t md(input int rd, input int we, input int id);
    mem_metadata_t m;
    m.rd = 5'(rd);
    m.we = 1'(we);
    m.id = 4'(id);
    return m;
  endfunction

  task automatic chk_a_reset(input string tag);
    chk({tag, ".pop_valid"},  32'(a_pop_valid), 0);
    chk({tag, ".empty"},      32'(a_empty), 1);
    chk({tag, ".full"},       32'(a_full), 0);
    chk({tag, ".usage"},      32'(a_usage), 0);
    chk({tag, ".ovf"},        32'(a_ovf), 0);
    chk({tag, ".udf"},        32'(a_udf), 0);
    chk({tag, ".push_ready"}, 32'(a_push_ready), 1);
    chk({tag, ".pop_data"},   32'(a_pop_data), 0);
  endtask

  initial begin
    rst = 1'b1;
    a_push_valid = 0; a_pop_ready = 0; a_flush = 0; a_push_data = '0;
    b_push_valid = 0; b_pop_ready = 0; b_flush = 0; b_push_data = '0;
    step(); step();
    rst = 1'b0;
    chk_a_reset("rst");

    // single push / pop
    a_push_valid = 1; a_push_data = md(5, 1, 3);
    step();
    a_push_valid = 0;
    chk("p1.valid", 32'(a_pop_valid), 1);
    chk("p1.rd",    32'(a_pop_data.rd), 5);
    chk("p1.we",    32'(a_pop_data.we), 1);
    chk("p1.id",    32'(a_pop_data.id), 3);
    chk("p1.usage", 32'(a_usage), 1);
    a_pop_ready = 1;
    step();
    a_pop_ready = 0;
    chk("p1.empty", 32'(a_empty), 1);
    chk("p1.zero",  32'(a_pop_data), 0);

    // fill to DEPTH=4
    for (int i = 0; i < 4; i++) begin
      a_push_valid = 1; a_push_data = md(i + 1, 0, i);
      step();
    end
    chk("fill.full",  32'(a_full), 1);
    chk("fill.ready", 32'(a_push_ready), 0);
    chk("fill.ovf0",  32'(a_ovf), 0);
    a_push_data = md(9, 1, 4);  // fifth push while full
    step();
    a_push_valid = 0;
    chk("ovf.set",   32'(a_ovf), 1);
    chk("ovf.head",  32'(a_pop_data.id), 0);
    chk("ovf.usage", 32'(a_usage), 4);

    // full + simultaneous push/pop: pop proceeds, push refused
    a_push_valid = 1; a_push_data = md(2, 1, 12); a_pop_ready = 1;
    step();
    a_push_valid = 0; a_pop_ready = 0;
    chk("fpp.usage", 32'(a_usage), 3);
    chk("fpp.ovf",   32'(a_ovf), 1);
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("drain.id%0d", i), 32'(a_pop_data.id), 32'(i));
      chk($sformatf("drain.rd%0d", i), 32'(a_pop_data.rd), 32'(i + 1));
      a_pop_ready = 1;
      step();
      a_pop_ready = 0;
    end
    chk("drain.empty", 32'(a_empty), 1);

    // flush with two entries and a same-cycle push
    a_push_valid = 1; a_push_data = md(1, 1, 1); step();
    a_push_data = md(1, 1, 2); step();
    chk("fl.pre", 32'(a_usage), 2);
    a_flush = 1; a_push_data = md(7, 1, 7);
    step();
    a_flush = 0; a_push_valid = 0;
    chk("fl.empty", 32'(a_empty), 1);
    chk("fl.usage", 32'(a_usage), 0);
    chk("fl.ovf",   32'(a_ovf), 1);
    a_push_valid = 1; a_push_data = md(3, 0, 9);
    step();
    a_push_valid = 0;
    chk("fl.id9",   32'(a_pop_data.id), 9);
    chk("fl.usage1", 32'(a_usage), 1);
    a_pop_ready = 1; step(); a_pop_ready = 0;

    // underflow
    a_pop_ready = 1;
    step();
    a_pop_ready = 0;
    chk("udf.set",   32'(a_udf), 1);
    chk("udf.usage", 32'(a_usage), 0);
    chk("udf.valid", 32'(a_pop_valid), 0);
    a_push_valid = 1; a_push_data = md(4, 1, 5); step();
    a_push_data = md(4, 1, 6); step();
    a_push_valid = 0;
    chk("udf.head", 32'(a_pop_data.id), 5);
    chk("udf.usage2", 32'(a_usage), 2);

    // reset mid-traffic with a push pending
    rst = 1; a_push_valid = 1; a_push_data = md(8, 1, 8); a_pop_ready = 1;
    step();
    rst = 0; a_push_valid = 0; a_pop_ready = 0;
    chk_a_reset("mrst");
    a_push_valid = 1; a_push_data = md(6, 1, 11);
    step();
    a_push_valid = 0;
    chk("mrst.id", 32'(a_pop_data.id), 11);
    chk("mrst.usage", 32'(a_usage), 1);

    // DEPTH=3: one pre-push then 10 cycles of push+pop across the wrap
    b_push_valid = 1; b_push_data = md(0, 1, 0);
    step();
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("b.id%0d", i),    32'(b_pop_data.id), 32'(i));
      chk($sformatf("b.usage%0d", i), 32'(b_usage), 1);
      b_push_data = md(i + 1, 1, i + 1); b_pop_ready = 1;
      step();
    end
    b_pop_ready = 0;
    chk("b.last", 32'(b_pop_data.id), 10);
    b_push_data = md(0, 0, 11); step();
    b_push_data = md(0, 0, 12); step();
    b_push_valid = 0;
    chk("b.full",  32'(b_full), 1);
    chk("b.usage", 32'(b_usage), 3);
    chk("b.ovf",   32'(b_ovf), 0);
    for (int i = 10; i < 13; i++) begin
      chk($sformatf("b.drain%0d", i), 32'(b_pop_data.id), 32'(i));
      b_pop_ready = 1; step(); b_pop_ready = 0;
    end
    chk("b.empty", 32'(b_empty), 1);
    chk("b.udf",   32'(b_udf), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
